// File: rtl/ammod_xmit.sv
// rtl/ammod_xmit.sv - parametrised AM transmit modulator; optional PWM output stage under AMMOD_PWM_EN
module ammod_xmit #(
  parameter int IW      = 12,
  parameter int GW      = 16,
  parameter int CW      = 12,
  parameter int NLANE   = 2,
  parameter int RAMP_LG = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic signed [IW-1:0] i_sample,
  input  logic                 i_rf_en,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [1:0]           i_wb_addr,
  input  logic [31:0]          i_wb_data,
  input  logic [3:0]           i_wb_sel,
  output logic                 o_wb_stall,
  output logic                 o_wb_ack,
  output logic [31:0]          o_wb_data,
  output logic [NLANE-1:0]     o_rf_data
);

  localparam int SHW = $clog2(IW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  // control registers
  logic signed [GW-1:0]    gain;
  logic signed [CW-1:0]    carrier;
  logic                    ctrl_en;
  logic                    ctrl_mode;
  logic [15:0]             clip_cnt;

  // ramp state
  state_t                  state;
  logic [SHW-1:0]          sh;
  logic [RAMP_LG-1:0]      tick_cnt;
  logic                    tick;
  logic                    en_all;

  // datapath
  logic signed [IW+GW-1:0] p_r;
  logic                    ce_d1;
  logic signed [IW:0]      a_c;
  logic signed [IW-1:0]    car_sh;
  logic signed [IW+1:0]    s_c;
  logic                    ovf_c;
  logic signed [IW-1:0]    sat_c;
  logic signed [IW-1:0]    sat_r;
  logic [IW-1:0]           u_c;
  logic [IW-1:0]           u_eff;

  // output stage
  logic [IW:0]             acc;
  logic [IW:0]             acc_next;
  logic                    out_bit;

  // bus decode
  logic                    wb_wr;
  logic                    clip_clear;
  logic [31:0]             rd_c;
  logic                    unused_bits;

  assign o_wb_stall  = 1'b0;
  assign wb_wr       = i_wb_cyc & i_wb_stb & i_wb_we;
  assign clip_clear  = wb_wr && (i_wb_addr == 2'd1) && i_wb_data[2];
  assign en_all      = ctrl_en & i_rf_en;
  assign tick        = &tick_cnt;
  assign unused_bits = ^{i_wb_sel, i_wb_data, p_r[GW-2:0]};

  // register writes from the control port
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      gain      <= GW'(1) << (GW - 2);
      carrier   <= '0;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 1'b0;
    end else if (wb_wr) begin
      case (i_wb_addr)
        2'd0: begin
          gain    <= i_wb_data[GW-1:0];
          carrier <= i_wb_data[CW+15:16];
        end
        2'd1: begin
          ctrl_en <= i_wb_data[0];
`ifdef AMMOD_PWM_EN
          ctrl_mode <= i_wb_data[1];
`endif
        end
        default: ;
      endcase
    end
  end

  // stage 1: full-width product of sample and gain
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p_r   <= '0;
      ce_d1 <= 1'b0;
    end else begin
      ce_d1 <= i_ce;
      if (i_ce)
        p_r <= (IW+GW)'(i_sample) * (IW+GW)'(gain);
    end
  end

  // rescale by the Q1 gain, add the carrier and detect overflow of the IW-bit range
  assign a_c    = p_r[IW+GW-1:GW-1];
  assign car_sh = IW'(carrier) <<< (IW - CW);
  assign s_c    = (IW+2)'(a_c) + (IW+2)'(car_sh);
  assign ovf_c  = (s_c[IW+1:IW-1] != 3'b000) && (s_c[IW+1:IW-1] != 3'b111);

  // clamp toward the rail on the side the sum overflowed
  always_comb begin
    sat_c = s_c[IW-1:0];
    if (ovf_c)
      sat_c = s_c[IW+1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
  end

  // stage 2: hold the saturated sample and count clips; a clear wins over a coincident clip
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sat_r    <= '0;
      clip_cnt <= '0;
    end else begin
      if (ce_d1)
        sat_r <= sat_c;
      if (clip_clear)
        clip_cnt <= '0;
      else if (ce_d1 && ovf_c && (clip_cnt != 16'hFFFF))
        clip_cnt <= clip_cnt + 16'd1;
    end
  end

  // offset-binary level, attenuated by the ramp shift
  assign u_c      = {~sat_r[IW-1], sat_r[IW-2:0]};
  assign u_eff    = u_c >> sh;
  assign acc_next = {1'b0, acc[IW-1:0]} + {1'b0, u_eff};

`ifdef AMMOD_PWM_EN
  logic [IW-1:0] cnt;
  logic [IW-1:0] cnt_rev;

  // bit-reversed counter spreads PWM ones evenly over the period
  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < IW; i++)
      cnt_rev[i] = cnt[IW-1-i];
  end

  assign out_bit = ctrl_mode ? (u_eff > cnt_rev) : acc_next[IW];

  // free-running PWM phase counter
  always_ff @(posedge i_clk) begin
    if (i_reset)
      cnt <= '0;
    else
      cnt <= cnt + IW'(1);
  end
`else
  assign out_bit = acc_next[IW];
`endif

  // first-order sigma-delta accumulator and lane drive; lanes are silent while idle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc       <= '0;
      o_rf_data <= '0;
    end else begin
      acc <= acc_next;
      if (state == S_IDLE)
        o_rf_data <= '0;
      else
        o_rf_data <= {NLANE{out_bit}};
    end
  end

  // soft ramp: shift walks between IW (silent) and 0 (full level) one step per tick
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      sh       <= SHW'(IW);
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + RAMP_LG'(1);
      case (state)
        S_IDLE: begin
          sh <= SHW'(IW);
          if (en_all) begin
            state    <= S_UP;
            tick_cnt <= '0;
          end
        end
        S_UP: begin
          if (!en_all) begin
            state    <= S_DOWN;
            tick_cnt <= '0;
          end else if (tick) begin
            if (sh <= SHW'(1)) begin
              state    <= S_ON;
              sh       <= '0;
              tick_cnt <= '0;
            end else begin
              sh <= sh - SHW'(1);
            end
          end
        end
        S_ON: begin
          sh <= '0;
          if (!en_all) begin
            state    <= S_DOWN;
            tick_cnt <= '0;
          end
        end
        default: begin
          if (en_all) begin
            state    <= S_UP;
            tick_cnt <= '0;
          end else if (tick) begin
            if (sh >= SHW'(IW - 1)) begin
              state    <= S_IDLE;
              sh       <= SHW'(IW);
              tick_cnt <= '0;
            end else begin
              sh <= sh + SHW'(1);
            end
          end
        end
      endcase
    end
  end

  // read-back mux
  always_comb begin
    rd_c = '0;
    case (i_wb_addr)
      2'd0: begin
        rd_c[GW-1:0]    = gain;
        rd_c[CW+15:16]  = carrier;
      end
      2'd1:    rd_c[1:0] = {ctrl_mode, ctrl_en};
      2'd2:    rd_c = {state, 2'b00, 4'(sh), 8'h00, clip_cnt};
      default: rd_c = 32'(sat_r);
    endcase
  end

  // ack one clock after strobe, read data registered alongside it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= i_wb_stb;
      if (i_wb_stb)
        o_wb_data <= rd_c;
    end
  end

endmodule

// File: tb/tb_ammod_xmit.sv
// tb/tb_ammod_xmit.sv - directed self-checking bench for ammod_xmit
module tb_ammod_xmit;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic signed [11:0] sample;
  logic               rf_en;
  logic               cyc, stb, we;
  logic [1:0]         addr;
  logic [31:0]        wdata;
  logic [3:0]         sel;
  logic               stall, ack;
  logic [31:0]        rdata;
  logic [1:0]         rf;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ammod_xmit #(.IW(12), .GW(16), .CW(12), .NLANE(2), .RAMP_LG(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sample(sample), .i_rf_en(rf_en),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall), .o_wb_ack(ack),
    .o_wb_data(rdata), .o_rf_data(rf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // all bus tasks start and end on a falling edge and take one clock
  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    check("wr_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = rdata;
    check("rd_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_ce(input logic signed [11:0] s);
    sample = s; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic count_ones(input int n, output int c0, output int c1, output int tr);
    logic prev;
    c0 = 0; c1 = 0; tr = 0; prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c0 += int'(rf[0]);
      c1 += int'(rf[1]);
      if (k > 0 && rf[0] != prev) tr++;
      prev = rf[0];
    end
  endtask

  // expected {state, 2'b00, sh} for read j after the enable write (RAMP_LG=2 -> 4 clocks per step)
  // kind 0: plain ramp up; kind 1: rf_en dropped at j=26; kind 2: also re-raised at j=40
  function automatic logic [7:0] ramp_exp(input int kind, input int j);
    int st, sv;
    if (j == 0) begin st = 0; sv = 12; end
    else if (kind == 0) begin
      if (j <= 48) begin st = 1; sv = 12 - (j - 1) / 4; end
      else begin st = 2; sv = 0; end
    end
    else if (j <= 26) begin st = 1; sv = 12 - (j - 1) / 4; end
    else if (kind == 2 && j > 40) begin st = 1; sv = 9 - (j - 41) / 4; end
    else if (j <= 50) begin st = 3; sv = 6 + (j - 27) / 4; end
    else begin st = 0; sv = 12; end
    return {st[1:0], 2'b00, sv[3:0]};
  endfunction

  task automatic run_ramp(input int kind, input int jmax);
    logic [31:0] d;
    rf_en = 1'b1;
    wb_write(2'd1, 32'd1);
    for (int j = 0; j <= jmax; j++) begin
      if (kind > 0 && j == 26) rf_en = 1'b0;
      if (kind == 2 && j == 40) rf_en = 1'b1;
      wb_read(2'd2, d);
      check($sformatf("ramp%0d_j%0d", kind, j), {24'd0, d[31:24]}, {24'd0, ramp_exp(kind, j)});
      if (kind == 1 && j >= 52)
        check($sformatf("idle_lanes_j%0d", j), {30'd0, rf}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int c0, c1, tr, expc;
    int          tg [7] = '{'h4000, 'h4000, 'h8000, 'h7FFF, 'h4000, 'hC000, 'h4000};
    int          tc [7] = '{0, 0, 0, 'h800, 'h100, 0, 'h7FF};
    int          ts [7] = '{1000, -2048, -2048, -2048, 100, 3, -7};
    logic [31:0] te [7] = '{32'h1F4, 32'hFFFFFC00, 32'h7FF, 32'hFFFFF800, 32'h132, 32'hFFFFFFFE, 32'h7FB};
    int          tk [7] = '{0, 0, 1, 1, 0, 0, 0};

    rst = 1'b1; ce = 1'b0; sample = '0; rf_en = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 4'hF;
    @(negedge clk);
    check("rst_rf", {30'd0, rf}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    wb_read(2'd0, d); check("rst_gain", d, 32'h0000_4000);
    wb_read(2'd1, d); check("rst_ctrl", d, 32'h0);
    wb_read(2'd2, d); check("rst_status", d, 32'h0C00_0000);
    wb_read(2'd3, d); check("rst_sample", d, 32'h0);

    // ramp up to ON, then sigma-delta at u=2048
    run_ramp(0, 52);
    count_ones(4096, c0, c1, tr);
    check("sd2048_l0", 32'(c0), 32'd2048);
    check("sd2048_l1", 32'(c1), 32'd2048);
    check("sd2048_alt", 32'(tr), 32'd4095);

    // clipping and the clip counter
    wb_write(2'd0, 32'h07FF_7FFF);
    sample = 12'sd2047; ce = 1'b1;
    repeat (5) @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    wb_read(2'd2, d); check("clip_cnt5", {16'd0, d[15:0]}, 32'd5);
    wb_read(2'd3, d); check("clip_sat", d, 32'h7FF);
    pulse_ce(12'sd2047);
    wb_write(2'd1, 32'h5);
    repeat (2) @(negedge clk);
    wb_read(2'd2, d); check("clip_clr_same", {16'd0, d[15:0]}, 32'd0);
    wb_read(2'd1, d); check("ctrl_bit2_rd0", d, 32'h1);
    pulse_ce(12'sd2047);
    repeat (2) @(negedge clk);
    wb_read(2'd2, d); check("clip_after_clr", {16'd0, d[15:0]}, 32'd1);
    wb_write(2'd1, 32'h5);
    expc = 0;

    // datapath vectors
    for (int k = 0; k < 7; k++) begin
      wb_write(2'd0, {4'd0, 12'(tc[k]), 16'(tg[k])});
      pulse_ce(12'(ts[k]));
      repeat (2) @(negedge clk);
      wb_read(2'd3, d); check($sformatf("sat_v%0d", k), d, te[k]);
      expc += tk[k];
      wb_read(2'd2, d); check($sformatf("clip_v%0d", k), {16'd0, d[15:0]}, 32'(expc));
    end

    // pipeline latency and hold
    wb_write(2'd0, 32'h0000_4000);
    pulse_ce(12'sd1000);
    wb_read(2'd3, d); check("sat_lat_old", d, 32'h7FB);
    wb_read(2'd3, d); check("sat_lat_new", d, 32'h1F4);
    sample = -12'sd5;
    repeat (5) @(negedge clk);
    wb_read(2'd3, d); check("sat_hold", d, 32'h1F4);

    // u=1024: PWM when built in, sigma-delta otherwise; both give 1024 ones per 4096
    pulse_ce(-12'sd2048);
    repeat (3) @(negedge clk);
    wb_write(2'd1, 32'h3);
    wb_read(2'd1, d);
`ifdef AMMOD_PWM_EN
    check("ctrl_mode", d, 32'h3);
`else
    check("ctrl_mode", d, 32'h1);
`endif
    repeat (2) @(negedge clk);
    count_ones(4096, c0, c1, tr);
    check("u1024_l0", 32'(c0), 32'd1024);
    check("u1024_l1", 32'(c1), 32'd1024);

    // drop and re-raise rf_en mid-ramp
    do_reset();
    run_ramp(1, 56);
    do_reset();
    run_ramp(2, 60);

    // reset in the middle of a ramp-down
    do_reset();
    wb_write(2'd0, 32'h0000_1234);
    run_ramp(1, 35);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rf", {30'd0, rf}, 32'd0);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    wb_read(2'd2, d); check("midrst_status", d, 32'h0C00_0000);
    wb_read(2'd0, d); check("midrst_gain", d, 32'h0000_4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
